dmem_bus_arbiter: RTL

- Two-master arbiter in front of the single-ported data memory / peripheral space of the pipelined MIPS core.
- Shares that memory between the pipeline MEM stage (CPU, default owner) and a DMA requester, such as a UART receive/transmit engine.
- Memory reads are combinational; writes commit on posedge clk.
- Stalls the CPU while the DMA owns the port, bounds DMA bursts, and prevents starvation of either master.

---
 rtl/dmem_bus_arbiter_if.sv | 42 ++++
 rtl/dmem_bus_arbiter.sv | 108 ++++++++++
 2 files changed

// File: rtl/dmem_bus_arbiter_if.sv
// Bus bundle between the CPU MEM stage, a DMA requester and the single-ported
// data memory. The arbiter takes the slave side; masters and memory use master.
interface dmem_bus_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [31:0] dma_rdata;
  logic        dma_ack;
  logic        dma_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall,
    output dma_rdata, dma_ack, dma_err,
    output mem_addr, mem_wdata, mem_read, mem_write
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall,
    input  dma_rdata, dma_ack, dma_err,
    input  mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/dmem_bus_arbiter.sv
// Two-master arbiter (CPU parked owner, DMA requester) for the single-ported
// data memory, with DMA starvation guard and bounded DMA bursts.
module dmem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_BURST    = 8,
  parameter logic [31:0] PERIPH_BASE  = 32'h4000_0000
) (
  input  logic               clk,
  input  logic               reset,
  dmem_bus_arbiter_if.slave  bus,
  output logic               owner
);
  localparam int WAIT_W  = $clog2(STARVE_LIMIT) + 1;
  localparam int BURST_W = $clog2(MAX_BURST) + 1;
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(STARVE_LIMIT - 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

  typedef enum logic {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } state_t;

  state_t               state_reg, state_next;
  logic [WAIT_W-1:0]    wait_cnt_reg, wait_cnt_next;
  logic [BURST_W-1:0]   burst_cnt_reg, burst_cnt_next;
  logic                 dma_illegal;

  assign dma_illegal = (bus.dma_addr >= PERIPH_BASE);
  assign owner       = (state_reg == S_DMA);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= S_CPU;
      wait_cnt_reg  <= '0;
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;
    burst_cnt_next = burst_cnt_reg;
    bus.cpu_rdata  = '0;
    bus.cpu_stall  = 1'b0;
    bus.dma_rdata  = '0;
    bus.dma_ack    = 1'b0;
    bus.dma_err    = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;

    // Outputs stay quiet for as long as reset is held, not just until a clock edge.
    if (reset) begin
      case (state_reg)
        S_CPU: begin
          bus.mem_addr   = bus.cpu_addr;
          bus.mem_wdata  = bus.cpu_wdata;
          bus.mem_read   = bus.cpu_req & ~bus.cpu_we;
          bus.mem_write  = bus.cpu_req &  bus.cpu_we;
          bus.cpu_rdata  = bus.mem_rdata;
          burst_cnt_next = '0;
          if (!bus.dma_req) begin
            wait_cnt_next = '0;
          end else if (!bus.cpu_req || wait_cnt_reg == WAIT_LAST) begin
            state_next    = S_DMA;
            wait_cnt_next = '0;
          end else begin
            wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
          end
        end

        S_DMA: begin
          bus.mem_addr  = bus.dma_addr;
          bus.mem_wdata = bus.dma_wdata;
          bus.cpu_stall = bus.cpu_req;
          bus.dma_ack   = bus.dma_req;
          wait_cnt_next = '0;
          // Peripheral-window beats are acked with an error but never reach memory.
          if (dma_illegal) begin
            bus.dma_err = bus.dma_req;
          end else begin
            bus.mem_read  = bus.dma_req & ~bus.dma_we;
            bus.mem_write = bus.dma_req &  bus.dma_we;
            bus.dma_rdata = bus.dma_req ? bus.mem_rdata : '0;
          end
          if (!bus.dma_req) begin
            state_next     = S_CPU;
            burst_cnt_next = '0;
          end else if (bus.cpu_req) begin
            if (burst_cnt_reg == BURST_LAST) begin
              state_next     = S_CPU;
              burst_cnt_next = '0;
            end else begin
              burst_cnt_next = burst_cnt_reg + BURST_W'(1);
            end
          end
        end

        default: state_next = S_CPU;
      endcase
    end
  end
endmodule
